// File: rtl/dct_pkg.sv
// dct_pkg: shared sizes and sample type for the 2D-DCT datapath
package dct_pkg;
  localparam int DCT_N = 8;
  localparam int DCT_IN_W = 9;
  localparam int DCT_COL_W = 10;
  typedef logic signed [DCT_IN_W-1:0] sample_t;
endpackage

// File: rtl/dct_tbuf_bank.sv
// dct_tbuf_bank: one 8x8 sample bank, written a row at a time, read a column at a time
module dct_tbuf_bank
  import dct_pkg::*;
(
  input  logic                          clk,
  input  logic                          we,
  input  logic [2:0]                    row,
  input  logic [DCT_N*DCT_IN_W-1:0]     wdata,
  input  logic [2:0]                    col,
  output logic [DCT_N*DCT_IN_W-1:0]     rdata
);
  sample_t mem [DCT_N][DCT_N];
  // row write; sample 0 sits in the top slice of the packed row
  always_ff @(posedge clk)
    if (we)
      for (int c = 0; c < DCT_N; c++)
        mem[row][c] <= wdata[(DCT_N-1-c)*DCT_IN_W +: DCT_IN_W];
  // column read; row 0 lands in the top slice of the packed column
  always_comb begin
    rdata = '0;
    for (int r = 0; r < DCT_N; r++)
      rdata[(DCT_N-1-r)*DCT_IN_W +: DCT_IN_W] = mem[r][col];
  end
endmodule

// File: rtl/dct_transpose_buffer.sv
// dct_transpose_buffer: ping-pong 8x8 transpose buffer between row and column DCT (DCT_TRANSPOSE_SINGLE_BANK_EN selects one bank)
module dct_transpose_buffer
  import dct_pkg::*;
#(
  parameter int DW = DCT_IN_W,
  parameter int N  = DCT_N
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] in_row,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*DW-1:0] out_col,
  output logic [2:0]      out_idx,
  output logic            out_last
);
  logic [1:0] full, set_f, clr_f;
  logic wb, rb, acc, drn;
  logic [2:0] wr_row, rd_col;
  logic [N*DW-1:0] d0;
  assign in_ready  = !full[wb];
  assign out_valid = full[rb];
  assign out_idx   = rd_col;
  assign out_last  = rd_col == 3'd7;
  assign acc = in_valid && in_ready;
  assign drn = out_valid && out_ready;
  // a block completes on its 8th row and retires on its 8th column; they never hit the same bank together
  always_comb begin
    set_f = (acc && wr_row == 3'd7) ? 2'b01 << wb : 2'b00;
    clr_f = (drn && rd_col == 3'd7) ? 2'b01 << rb : 2'b00;
  end
  // bank flags and row/column counters
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      full   <= 2'b00;
      wr_row <= 3'd0;
      rd_col <= 3'd0;
    end else begin
      full <= (full | set_f) & ~clr_f;
      if (acc) wr_row <= wr_row + 3'd1;
      if (drn) rd_col <= rd_col + 3'd1;
    end
`ifdef DCT_TRANSPOSE_SINGLE_BANK_EN
  assign wb = 1'b0;
  assign rb = 1'b0;
  assign out_col = out_valid ? d0 : '0;
  dct_tbuf_bank u_bank0 (.clk(clk), .we(acc), .row(wr_row), .wdata(in_row), .col(rd_col), .rdata(d0));
`else
  logic [N*DW-1:0] d1;
  // write pointer flips after a block fills, read pointer after a block drains
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wb <= 1'b0;
      rb <= 1'b0;
    end else begin
      if (|set_f) wb <= !wb;
      if (|clr_f) rb <= !rb;
    end
  assign out_col = !out_valid ? '0 : rb ? d1 : d0;
  dct_tbuf_bank u_bank0 (.clk(clk), .we(acc && !wb), .row(wr_row), .wdata(in_row), .col(rd_col), .rdata(d0));
  dct_tbuf_bank u_bank1 (.clk(clk), .we(acc && wb), .row(wr_row), .wdata(in_row), .col(rd_col), .rdata(d1));
`endif
endmodule

// File: tb/tb_dct_transpose_buffer.sv
// tb_dct_transpose_buffer: directed stimulus with a column scoreboard for dct_transpose_buffer
module tb_dct_transpose_buffer;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
  logic [71:0] in_row = '0;
  logic in_ready, out_valid, out_last;
  logic [71:0] out_col;
  logic [2:0] out_idx;
  int checks = 0, errors = 0, stalls = 0, mrow = 0;
  typedef struct { logic [71:0] col; logic [2:0] idx; logic last; } exp_t;
  exp_t q[$];
  logic [71:0] mrows [8];

  dct_transpose_buffer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
    .out_valid(out_valid), .out_ready(out_ready), .out_col(out_col), .out_idx(out_idx), .out_last(out_last)
  );

  always #5 clk = ~clk;

  function automatic logic [71:0] gen_row(input int b, input int r);
    logic [71:0] d;
    logic [31:0] v;
    d = '0;
    for (int c = 0; c < 8; c++) begin
      v = 8*r + c + 64*b;
      d[(7-c)*9 +: 9] = v[8:0];
    end
    return d;
  endfunction

  function automatic logic [71:0] gen_col(input int b, input int c);
    logic [71:0] d;
    logic [31:0] v;
    d = '0;
    for (int r = 0; r < 8; r++) begin
      v = 8*r + c + 64*b;
      d[(7-r)*9 +: 9] = v[8:0];
    end
    return d;
  endfunction

  always @(negedge clk) if (rst_n) begin
    exp_t e;
    logic [71:0] col;
    if (!out_valid) begin
      checks++;
      assert (out_col === 72'd0) else begin errors++; $error("FAIL idle_col got %h exp 0", out_col); end
    end
    if (out_valid && out_ready) begin
      checks++;
      assert (q.size() > 0) else begin errors++; $error("FAIL unexpected_col got idx %0d exp none", out_idx); end
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        assert (out_col === e.col && out_idx === e.idx && out_last === e.last)
          else begin errors++; $error("FAIL col got %h/%0d/%b exp %h/%0d/%b", out_col, out_idx, out_last, e.col, e.idx, e.last); end
      end
    end
    if (in_valid && in_ready) begin
      mrows[mrow] = in_row;
      if (mrow == 7)
        for (int c = 0; c < 8; c++) begin
          for (int r = 0; r < 8; r++) col[(7-r)*9 +: 9] = mrows[r][(7-c)*9 +: 9];
          e.col = col; e.idx = 3'(c); e.last = (c == 7);
          q.push_back(e);
        end
      mrow = (mrow + 1) % 8;
    end
  end

  task automatic put_row(input logic [71:0] d);
    int n;
    n = 0;
    in_valid = 1;
    in_row = d;
    @(negedge clk);
    while (!in_ready && n < 40) begin stalls++; n++; @(negedge clk); end
    checks++;
    assert (in_ready === 1'b1) else begin errors++; $error("FAIL put_row_timeout got in_ready=%b exp 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin @(posedge clk); n++; end
    #1;
    checks++;
    assert (q.size() == 0) else begin errors++; $error("FAIL drain_timeout got %0d pending exp 0", q.size()); end
  endtask

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    assert (got === exp) else begin errors++; $error("FAIL %s got %h exp %h", tag, got, exp); end
  endtask

  initial begin
    logic [71:0] d;
    int nblk, exp_stalls;
`ifdef DCT_TRANSPOSE_SINGLE_BANK_EN
    nblk = 1; exp_stalls = 16;
`else
    nblk = 2; exp_stalls = 0;
`endif
    #12;
    chk("rst_in_ready", 72'(in_ready), 72'd1);
    chk("rst_out_valid", 72'(out_valid), 72'd0);
    chk("rst_out_idx", 72'(out_idx), 72'd0);
    chk("rst_out_last", 72'(out_last), 72'd0);
    chk("rst_out_col", out_col, 72'd0);
    @(posedge clk); #1 rst_n = 1;

    for (int r = 0; r < 8; r++) put_row(gen_row(0, r));
    chk("t1_valid", 72'(out_valid), 72'd1);
    chk("t1_idx0", 72'(out_idx), 72'd0);
    chk("t1_col0", out_col, gen_col(0, 0));
    repeat (7) @(posedge clk);
    #1;
    chk("t1_idx7", 72'(out_idx), 72'd7);
    chk("t1_last", 72'(out_last), 72'd1);
    chk("t1_col7", out_col, gen_col(0, 7));
    wait_drain();

    stalls = 0;
    for (int b = 0; b < 3; b++)
      for (int r = 0; r < 8; r++) put_row(gen_row(b, r));
    chk("t2_stalls", 72'(stalls), 72'(exp_stalls));
    wait_drain();

    out_ready = 0;
    for (int b = 0; b < nblk; b++)
      for (int r = 0; r < 8; r++) put_row(gen_row(b + 2, r));
    in_valid = 1;
    in_row = {8{9'h1AA}};
    repeat (4) begin
      @(negedge clk);
      chk("t3_stall_ready", 72'(in_ready), 72'd0);
      chk("t3_hold_idx", 72'(out_idx), 72'd0);
      chk("t3_hold_col", out_col, gen_col(2, 0));
    end
    @(posedge clk); #1;
    in_valid = 0;
    out_ready = 1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("t3_ready_before", 72'(in_ready), 72'd0);
    chk("t3_last_before", 72'(out_last), 72'd1);
    @(posedge clk); #1;
    chk("t3_ready_after", 72'(in_ready), 72'd1);
    wait_drain();

    for (int r = 0; r < 8; r++) begin
      d = gen_row(0, r);
      if (r == 0) d[71:63] = 9'h100;
      if (r == 7) d[8:0] = 9'h0FF;
      put_row(d);
    end
    chk("t4_corner00", 72'(out_col[71:63]), 72'h100);
    repeat (7) @(posedge clk);
    #1;
    chk("t4_corner77", 72'(out_col[8:0]), 72'h0FF);
    chk("t4_last", 72'(out_last), 72'd1);
    wait_drain();

    for (int r = 0; r < 5; r++) put_row(gen_row(6, r));
    rst_n = 0;
    #1;
    chk("t5_rst_valid", 72'(out_valid), 72'd0);
    chk("t5_rst_ready", 72'(in_ready), 72'd1);
    mrow = 0;
    q.delete();
    @(posedge clk); @(posedge clk); #1 rst_n = 1;
    for (int r = 0; r < 7; r++) put_row(gen_row(5, r));
    chk("t5_partial_valid", 72'(out_valid), 72'd0);
    put_row(gen_row(5, 7));
    chk("t5_valid", 72'(out_valid), 72'd1);
    chk("t5_col0", out_col, gen_col(5, 0));
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
